// File: rtl/park_gate_arbiter.sv
// Parking gate controller: round-robin entry/exit arbitration, entry password check, occupancy count.
// Grants one cycle after the sampled request; define PARK_PWD_TIMEOUT_EN to bound the CHECK_PWD wait.
module park_gate_arbiter #(
  parameter int CAPACITY    = 8,
  parameter int CNT_W       = 4,
  parameter int PWD_TIMEOUT = 16,
  parameter int CLOSE_HOLD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             pass_sensor,
  input  logic             passwd_valid,
  input  logic             passwd_ok,
  output logic             passwd_rqst,
  output logic             gate_open,
  output logic             gate_close,
  output logic             grant_entry,
  output logic             grant_exit,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             pwd_fail
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK_PWD = 3'd1,
    S_OPEN_IN   = 3'd2,
    S_OPEN_OUT  = 3'd3,
    S_CLOSE     = 3'd4
  } state_t;

  localparam int CL_W = $clog2(CLOSE_HOLD + 1);

  state_t          state;
  state_t          state_nxt;
  logic            last_entry;
  logic [CL_W-1:0] close_cnt;
  logic            close_done;
  logic            entry_ok;
  logic            exit_ok;
  logic            pwd_timeout;

  assign full       = (occupancy == CNT_W'(CAPACITY));
  assign empty      = (occupancy == '0);
  assign entry_ok   = entry_req && !full;
  assign exit_ok    = exit_req && !empty;
  assign close_done = (close_cnt == CL_W'(CLOSE_HOLD - 1));

`ifdef PARK_PWD_TIMEOUT_EN
  localparam int PT_W = $clog2(PWD_TIMEOUT + 1);
  logic [PT_W-1:0] pwd_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != S_CHECK_PWD) pwd_cnt <= '0;
    else                             pwd_cnt <= pwd_cnt + PT_W'(1);
  end

  assign pwd_timeout = (pwd_cnt == PT_W'(PWD_TIMEOUT - 1));
`else
  // Timeout disabled: CHECK_PWD waits for passwd_valid indefinitely.
  assign pwd_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        // Both eligible: the lane not served last time wins.
        if (entry_ok && (!exit_ok || !last_entry)) state_nxt = S_CHECK_PWD;
        else if (exit_ok)                          state_nxt = S_OPEN_OUT;
      end
      S_CHECK_PWD: begin
        if (passwd_valid)     state_nxt = passwd_ok ? S_OPEN_IN : S_IDLE;
        else if (pwd_timeout) state_nxt = S_IDLE;
      end
      S_OPEN_IN, S_OPEN_OUT: begin
        if (pass_sensor) state_nxt = S_CLOSE;
      end
      S_CLOSE: begin
        if (close_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    passwd_rqst = 1'b0;
    gate_open   = 1'b0;
    gate_close  = 1'b0;
    grant_entry = 1'b0;
    grant_exit  = 1'b0;
    case (state)
      S_CHECK_PWD: begin
        passwd_rqst = 1'b1;
        grant_entry = 1'b1;
      end
      S_OPEN_IN: begin
        gate_open   = 1'b1;
        grant_entry = 1'b1;
      end
      S_OPEN_OUT: begin
        gate_open  = 1'b1;
        grant_exit = 1'b1;
      end
      S_CLOSE: gate_close = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_entry <= 1'b0;
      pwd_fail   <= 1'b0;
      close_cnt  <= '0;
      occupancy  <= '0;
    end else begin
      if (state == S_IDLE && state_nxt == S_CHECK_PWD) last_entry <= 1'b1;
      if (state == S_IDLE && state_nxt == S_OPEN_OUT)  last_entry <= 1'b0;
      pwd_fail <= (state == S_CHECK_PWD) && (state_nxt == S_IDLE);
      if (state == S_CLOSE) close_cnt <= close_cnt + CL_W'(1);
      else                  close_cnt <= '0;
      // Count moves on the same edge that leaves the open state; saturates at both ends.
      if (state == S_OPEN_IN && pass_sensor && !full)
        occupancy <= occupancy + CNT_W'(1);
      else if (state == S_OPEN_OUT && pass_sensor && !empty)
        occupancy <= occupancy - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_park_gate_arbiter.sv
// Self-checking bench for park_gate_arbiter: directed scenarios plus randomized traffic vs a lane/phase model.
module tb_park_gate_arbiter;
  localparam int CAPACITY    = 8;
  localparam int CNT_W       = 4;
  localparam int PWD_TIMEOUT = 16;
  localparam int CLOSE_HOLD  = 4;

  localparam int PH_IDLE  = 0;
  localparam int PH_PWD   = 1;
  localparam int PH_OPEN  = 2;
  localparam int PH_CLOSE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic entry_req = 1'b0, exit_req = 1'b0, pass_sensor = 1'b0;
  logic passwd_valid = 1'b0, passwd_ok = 1'b0;
  logic passwd_rqst, gate_open, gate_close, grant_entry, grant_exit, full, empty, pwd_fail;
  logic [CNT_W-1:0] occupancy;

  int checks = 0;
  int failures = 0;

  // Reference model: what the gate is doing (phase), which lane holds it, car count.
  int m_phase = PH_IDLE;
  bit m_lane_entry = 1'b0;
  int m_occ = 0;
  bit m_last_entry = 1'b0;
  bit m_fail = 1'b0;
  int m_close_left = 0;
  int m_pwd_wait = 0;

  always #5 clk = ~clk;

  park_gate_arbiter #(
    .CAPACITY(CAPACITY), .CNT_W(CNT_W), .PWD_TIMEOUT(PWD_TIMEOUT), .CLOSE_HOLD(CLOSE_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req),
    .pass_sensor(pass_sensor), .passwd_valid(passwd_valid), .passwd_ok(passwd_ok),
    .passwd_rqst(passwd_rqst), .gate_open(gate_open), .gate_close(gate_close),
    .grant_entry(grant_entry), .grant_exit(grant_exit), .occupancy(occupancy),
    .full(full), .empty(empty), .pwd_fail(pwd_fail)
  );

  task automatic model_update();
    bit want_in, want_out;
    if (rst) begin
      m_phase = PH_IDLE; m_occ = 0; m_last_entry = 1'b0; m_fail = 1'b0; m_close_left = 0;
      return;
    end
    m_fail = 1'b0;
    case (m_phase)
      PH_IDLE: begin
        want_in  = entry_req && (m_occ < CAPACITY);
        want_out = exit_req && (m_occ > 0);
        if (want_in && want_out) want_in = !m_last_entry;
        if (want_in) begin
          m_phase = PH_PWD; m_lane_entry = 1'b1; m_last_entry = 1'b1; m_pwd_wait = 0;
        end else if (want_out) begin
          m_phase = PH_OPEN; m_lane_entry = 1'b0; m_last_entry = 1'b0;
        end
      end
      PH_PWD: begin
        if (passwd_valid) begin
          if (passwd_ok) m_phase = PH_OPEN;
          else begin m_phase = PH_IDLE; m_fail = 1'b1; end
        end else begin
          m_pwd_wait++;
`ifdef PARK_PWD_TIMEOUT_EN
          if (m_pwd_wait == PWD_TIMEOUT) begin m_phase = PH_IDLE; m_fail = 1'b1; end
`endif
        end
      end
      PH_OPEN: begin
        if (pass_sensor) begin
          m_phase = PH_CLOSE; m_close_left = CLOSE_HOLD;
          if (m_lane_entry) m_occ = (m_occ < CAPACITY) ? m_occ + 1 : m_occ;
          else              m_occ = (m_occ > 0) ? m_occ - 1 : 0;
        end
      end
      default: begin
        m_close_left--;
        if (m_close_left == 0) m_phase = PH_IDLE;
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_in(input bit e, input bit x, input bit p, input bit v, input bit o);
    entry_req = e; exit_req = x; pass_sensor = p; passwd_valid = v; passwd_ok = o;
  endtask

  task automatic run_entry();
    set_in(1, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 1, 1); step();
    set_in(0, 0, 1, 0, 0); step();
    set_in(0, 0, 0, 0, 0);
    repeat (CLOSE_HOLD) step();
  endtask

  task automatic run_exit();
    set_in(0, 1, 0, 0, 0); step();
    set_in(0, 0, 1, 0, 0); step();
    set_in(0, 0, 0, 0, 0);
    repeat (CLOSE_HOLD) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; set_in(0, 0, 0, 0, 0);
    step(); step();
    checks++; if (gate_open !== 1'b0) begin failures++; $display("FAIL reset_gate_open got=%b exp=0", gate_open); end
    checks++; if (gate_close !== 1'b0) begin failures++; $display("FAIL reset_gate_close got=%b exp=0", gate_close); end
    checks++; if (passwd_rqst !== 1'b0) begin failures++; $display("FAIL reset_passwd_rqst got=%b exp=0", passwd_rqst); end
    checks++; if ({grant_entry, grant_exit} !== 2'b00) begin failures++; $display("FAIL reset_grants got=%b%b exp=00", grant_entry, grant_exit); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", empty, full); end
    checks++; if (pwd_fail !== 1'b0) begin failures++; $display("FAIL reset_pwd_fail got=%b exp=0", pwd_fail); end
    checks++; if (occupancy !== '0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    rst = 1'b0;
  endtask

  task automatic test_entry_flow();
    int n;
    set_in(1, 0, 0, 0, 0); step();
    checks++; if (passwd_rqst !== 1'b1 || grant_entry !== 1'b1 || gate_open !== 1'b0) begin failures++; $display("FAIL entry_check_pwd got rqst=%b ge=%b open=%b exp 1 1 0", passwd_rqst, grant_entry, gate_open); end
    set_in(0, 0, 0, 1, 1); step();
    checks++; if (gate_open !== 1'b1 || grant_entry !== 1'b1 || passwd_rqst !== 1'b0) begin failures++; $display("FAIL entry_open_in got open=%b ge=%b rqst=%b exp 1 1 0", gate_open, grant_entry, passwd_rqst); end
    set_in(0, 0, 0, 0, 0); step(); step();
    checks++; if (gate_open !== 1'b1 || gate_close !== 1'b0) begin failures++; $display("FAIL entry_hold_open got open=%b close=%b exp 1 0", gate_open, gate_close); end
    set_in(0, 0, 1, 0, 0); step();
    checks++; if (gate_close !== 1'b1 || gate_open !== 1'b0 || occupancy !== CNT_W'(1)) begin failures++; $display("FAIL entry_close got close=%b open=%b occ=%0d exp 1 0 1", gate_close, gate_open, occupancy); end
    set_in(0, 0, 0, 0, 0);
    n = 1;
    for (int k = 0; k < 10 && gate_close; k++) begin
      step();
      if (gate_close) n++;
    end
    checks++; if (n != CLOSE_HOLD) begin failures++; $display("FAIL entry_close_len got=%0d exp=%0d", n, CLOSE_HOLD); end
    checks++; if ({gate_open, gate_close, passwd_rqst, grant_entry, grant_exit} !== 5'b0 || empty !== 1'b0 || occupancy !== CNT_W'(1)) begin failures++; $display("FAIL entry_idle got outs=%b%b%b%b%b empty=%b occ=%0d exp 00000 0 1", gate_open, gate_close, passwd_rqst, grant_entry, grant_exit, empty, occupancy); end
  endtask

  task automatic test_pwd_reject();
    bit saw_open = 1'b0;
    set_in(1, 0, 0, 0, 0); step();
    saw_open |= gate_open;
    set_in(0, 0, 0, 1, 0); step();
    saw_open |= gate_open;
    checks++; if (pwd_fail !== 1'b1 || passwd_rqst !== 1'b0) begin failures++; $display("FAIL reject_pulse got fail=%b rqst=%b exp 1 0", pwd_fail, passwd_rqst); end
    set_in(0, 0, 0, 0, 0); step();
    saw_open |= gate_open;
    checks++; if (pwd_fail !== 1'b0) begin failures++; $display("FAIL reject_pulse_len got=%b exp=0", pwd_fail); end
    checks++; if (saw_open !== 1'b0 || occupancy !== CNT_W'(m_occ)) begin failures++; $display("FAIL reject_no_open got open_seen=%b occ=%0d exp 0 %0d", saw_open, occupancy, m_occ); end
  endtask

  task automatic test_round_robin();
    bit prev_entry = 1'b0;
    for (int r = 0; r < 3; r++) begin
      set_in(1, 1, 0, 0, 0); step();
      checks++; if (grant_entry !== m_lane_entry || grant_exit !== !m_lane_entry) begin failures++; $display("FAIL rr_grant round=%0d got ge=%b gx=%b exp ge=%b", r, grant_entry, grant_exit, m_lane_entry); end
      if (r > 0) begin
        checks++; if (grant_entry === prev_entry) begin failures++; $display("FAIL rr_alternate round=%0d got ge=%b exp ge=%b", r, grant_entry, !prev_entry); end
      end
      prev_entry = grant_entry;
      step();
      checks++; if (grant_entry !== prev_entry) begin failures++; $display("FAIL rr_hold round=%0d got ge=%b exp ge=%b", r, grant_entry, prev_entry); end
      if (m_lane_entry) begin set_in(0, 0, 0, 1, 1); step(); end
      set_in(0, 0, 1, 0, 0); step();
      set_in(0, 0, 0, 0, 0);
      repeat (CLOSE_HOLD) step();
    end
  endtask

  task automatic test_full();
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < CAPACITY; i++) run_entry();
    checks++; if (full !== 1'b1 || occupancy !== CNT_W'(CAPACITY)) begin failures++; $display("FAIL full_reached got full=%b occ=%0d exp 1 %0d", full, occupancy, CAPACITY); end
    set_in(1, 0, 0, 0, 0); step(); step();
    checks++; if (passwd_rqst !== 1'b0 || grant_entry !== 1'b0) begin failures++; $display("FAIL full_entry_ignored got rqst=%b ge=%b exp 0 0", passwd_rqst, grant_entry); end
    set_in(0, 0, 0, 0, 0);
    run_exit();
    checks++; if (full !== 1'b0 || occupancy !== CNT_W'(CAPACITY - 1)) begin failures++; $display("FAIL full_after_exit got full=%b occ=%0d exp 0 %0d", full, occupancy, CAPACITY - 1); end
  endtask

  task automatic test_pwd_wait();
    int n = 0;
    set_in(1, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0);
`ifdef PARK_PWD_TIMEOUT_EN
    for (int k = 0; k < 4 * PWD_TIMEOUT; k++) begin
      step(); n++;
      if (pwd_fail) break;
    end
    checks++; if (n != PWD_TIMEOUT || pwd_fail !== 1'b1 || passwd_rqst !== 1'b0) begin failures++; $display("FAIL pwd_timeout got cycles=%0d fail=%b rqst=%b exp %0d 1 0", n, pwd_fail, passwd_rqst, PWD_TIMEOUT); end
    step();
    checks++; if (pwd_fail !== 1'b0) begin failures++; $display("FAIL pwd_timeout_pulse got=%b exp=0", pwd_fail); end
`else
    repeat (100) begin
      step();
      if (passwd_rqst === 1'b1 && pwd_fail === 1'b0) n++;
    end
    checks++; if (n != 100) begin failures++; $display("FAIL pwd_wait_hold got=%0d exp=100", n); end
    set_in(0, 0, 0, 1, 0); step();
    checks++; if (pwd_fail !== 1'b1) begin failures++; $display("FAIL pwd_wait_reject got=%b exp=1", pwd_fail); end
    set_in(0, 0, 0, 0, 0); step();
`endif
  endtask

  task automatic test_reset_mid_open();
    set_in(1, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 1, 1); step();
    checks++; if (gate_open !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got open=%b exp=1", gate_open); end
    set_in(0, 0, 0, 0, 0); rst = 1'b1; step(); rst = 1'b0;
    checks++; if (gate_open !== 1'b0 || occupancy !== '0 || empty !== 1'b1 || grant_entry !== 1'b0) begin failures++; $display("FAIL rst_mid got open=%b occ=%0d empty=%b ge=%b exp 0 0 1 0", gate_open, occupancy, empty, grant_entry); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      set_in($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
      step();
      checks++; if (gate_open !== (m_phase == PH_OPEN)) begin failures++; $display("FAIL rnd_gate_open cyc=%0d got=%b exp=%b", i, gate_open, m_phase == PH_OPEN); end
      checks++; if (gate_close !== (m_phase == PH_CLOSE)) begin failures++; $display("FAIL rnd_gate_close cyc=%0d got=%b exp=%b", i, gate_close, m_phase == PH_CLOSE); end
      checks++; if (passwd_rqst !== (m_phase == PH_PWD)) begin failures++; $display("FAIL rnd_passwd_rqst cyc=%0d got=%b exp=%b", i, passwd_rqst, m_phase == PH_PWD); end
      checks++; if (grant_entry !== (m_phase == PH_PWD || (m_phase == PH_OPEN && m_lane_entry))) begin failures++; $display("FAIL rnd_grant_entry cyc=%0d got=%b", i, grant_entry); end
      checks++; if (grant_exit !== (m_phase == PH_OPEN && !m_lane_entry)) begin failures++; $display("FAIL rnd_grant_exit cyc=%0d got=%b", i, grant_exit); end
      checks++; if (occupancy !== CNT_W'(m_occ)) begin failures++; $display("FAIL rnd_occupancy cyc=%0d got=%0d exp=%0d", i, occupancy, m_occ); end
      checks++; if (full !== (m_occ == CAPACITY) || empty !== (m_occ == 0)) begin failures++; $display("FAIL rnd_flags cyc=%0d got full=%b empty=%b occ_exp=%0d", i, full, empty, m_occ); end
      checks++; if (pwd_fail !== m_fail) begin failures++; $display("FAIL rnd_pwd_fail cyc=%0d got=%b exp=%b", i, pwd_fail, m_fail); end
      checks++; if (gate_open === 1'b1 && gate_close === 1'b1) begin failures++; $display("FAIL rnd_open_close_excl cyc=%0d got both=1 exp not both", i); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_entry_flow();
    test_pwd_reject();
    test_round_robin();
    test_full();
    test_pwd_wait();
    test_reset_mid_open();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
